shared_bus_arbiter: RTL and testbench

- Round-robin arbiter and sequencer for the 128-bit shared data bus built from mux4 select paths and tri_buf drivers.
- Shares the bus between 4 requesters (e.g. fetch, two load/store lanes, refill) doing multi-beat bursts.
- Drives the mux4 `select` directly and drives one tri_buf `enable` per requester.
- Inserts a bus-turnaround gap between owners so no two tri_buf drivers ever overlap.

---
 rtl/shared_bus_arbiter.sv | 125 ++++++++++++
 tb/tb_shared_bus_arbiter.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/shared_bus_arbiter.sv
// rtl/shared_bus_arbiter.sv - round-robin burst arbiter and tri_buf sequencer for a 4-requester shared bus
module shared_bus_arbiter #(
    parameter int LEN_W       = 4,
    parameter int TURN_CYCLES = 1
) (
    input  logic               i_clk,
    input  logic               i_reset,
    input  logic [3:0]         i_req,
    input  logic [4*LEN_W-1:0] i_req_len,
    input  logic               i_bus_ready,
    output logic [3:0]         o_gnt,
    output logic [1:0]         o_sel,
    output logic [3:0]         o_drv_en,
    output logic [3:0]         o_beat_ack,
    output logic               o_last_beat,
    output logic               o_busy
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_XFER = 2'd1,
        ST_TURN = 2'd2
    } state_t;

    localparam logic [1:0] TURN_LAST = 2'((TURN_CYCLES > 0) ? TURN_CYCLES - 1 : 0);

    state_t           r_state;
    state_t           w_next_state;
    logic [3:0]       r_gnt;
    logic [1:0]       r_sel;
    logic [1:0]       r_rr_ptr;
    logic [LEN_W-1:0] r_beat_cnt;
    logic [LEN_W-1:0] r_len_q;
    logic [1:0]       r_turn_cnt;

    logic             w_any_req;
    logic [1:0]       w_winner;
    logic [1:0]       w_scan_idx;
    logic [LEN_W-1:0] w_winner_len;
    logic             w_is_last;
    logic             w_burst_done;

    // Scan starts at the round-robin pointer so the previous owner goes to the back of the line.
    always_comb begin
        w_any_req  = 1'b0;
        w_winner   = 2'd0;
        w_scan_idx = 2'd0;
        for (int i = 0; i < 4; i++) begin
            w_scan_idx = r_rr_ptr + 2'(i);
            if (!w_any_req && i_req[w_scan_idx]) begin
                w_any_req = 1'b1;
                w_winner  = w_scan_idx;
            end
        end
    end

    assign w_winner_len = i_req_len[w_winner*LEN_W +: LEN_W];
    assign w_is_last    = (r_beat_cnt == r_len_q);
    assign w_burst_done = (r_state == ST_XFER) && i_bus_ready && w_is_last;

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_IDLE: if (w_any_req) w_next_state = ST_XFER;
            ST_XFER: if (w_burst_done) w_next_state = (TURN_CYCLES > 0) ? ST_TURN : ST_IDLE;
            ST_TURN: if (r_turn_cnt == TURN_LAST) w_next_state = ST_IDLE;
            default: w_next_state = ST_IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_gnt      <= 4'd0;
            r_sel      <= 2'd0;
            r_rr_ptr   <= 2'd0;
            r_beat_cnt <= '0;
            r_len_q    <= '0;
            r_turn_cnt <= 2'd0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    r_turn_cnt <= 2'd0;
                    if (w_any_req) begin
                        r_gnt      <= 4'b0001 << w_winner;
                        r_sel      <= w_winner;
                        r_len_q    <= w_winner_len;
                        r_beat_cnt <= '0;
                    end
                end
                ST_XFER: begin
                    if (i_bus_ready) begin
                        if (w_is_last) begin
                            r_gnt      <= 4'd0;
                            r_rr_ptr   <= r_sel + 2'd1;
                            r_turn_cnt <= 2'd0;
                        end else begin
                            r_beat_cnt <= r_beat_cnt + 1'b1;
                        end
                    end
                end
                ST_TURN: r_turn_cnt <= r_turn_cnt + 2'd1;
                default: r_gnt <= 4'd0;
            endcase
        end
    end

    // Drivers are only ever enabled in XFER, so the turnaround gap keeps tri_bufs from overlapping.
    always_comb begin
        o_gnt       = r_gnt;
        o_sel       = r_sel;
        o_drv_en    = (r_state == ST_XFER) ? r_gnt : 4'd0;
        o_beat_ack  = o_drv_en & {4{i_bus_ready}};
        o_last_beat = w_burst_done;
        o_busy      = (r_state != ST_IDLE);
    end

endmodule

// File: tb/tb_shared_bus_arbiter.sv
// tb/tb_shared_bus_arbiter.sv - randomized bench for shared_bus_arbiter with TURN_CYCLES 1, 0 and 3
module tb_shared_bus_arbiter;

    localparam int LEN_W = 4;
    localparam int NDUT  = 3;

    logic             clk = 1'b0;
    logic             reset;
    logic [3:0]       req;
    logic [4*LEN_W-1:0] req_len;
    logic             bus_ready;

    logic [3:0] gnt_a      [NDUT];
    logic [1:0] sel_a      [NDUT];
    logic [3:0] drv_en_a   [NDUT];
    logic [3:0] beat_ack_a [NDUT];
    logic       last_a     [NDUT];
    logic       busy_a     [NDUT];

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;

    int turn_of [NDUT] = '{1, 0, 3};
    int m_owner [NDUT];
    int m_beats_done [NDUT];
    int m_beats_total [NDUT];
    int m_gap [NDUT];
    int m_ptr [NDUT];
    int m_sel [NDUT];

    always #5 clk = ~clk;

    shared_bus_arbiter #(.LEN_W(LEN_W), .TURN_CYCLES(1)) u_dut_t1 (
        .i_clk(clk), .i_reset(reset), .i_req(req), .i_req_len(req_len), .i_bus_ready(bus_ready),
        .o_gnt(gnt_a[0]), .o_sel(sel_a[0]), .o_drv_en(drv_en_a[0]), .o_beat_ack(beat_ack_a[0]),
        .o_last_beat(last_a[0]), .o_busy(busy_a[0]));

    shared_bus_arbiter #(.LEN_W(LEN_W), .TURN_CYCLES(0)) u_dut_t0 (
        .i_clk(clk), .i_reset(reset), .i_req(req), .i_req_len(req_len), .i_bus_ready(bus_ready),
        .o_gnt(gnt_a[1]), .o_sel(sel_a[1]), .o_drv_en(drv_en_a[1]), .o_beat_ack(beat_ack_a[1]),
        .o_last_beat(last_a[1]), .o_busy(busy_a[1]));

    shared_bus_arbiter #(.LEN_W(LEN_W), .TURN_CYCLES(3)) u_dut_t3 (
        .i_clk(clk), .i_reset(reset), .i_req(req), .i_req_len(req_len), .i_bus_ready(bus_ready),
        .o_gnt(gnt_a[2]), .o_sel(sel_a[2]), .o_drv_en(drv_en_a[2]), .o_beat_ack(beat_ack_a[2]),
        .o_last_beat(last_a[2]), .o_busy(busy_a[2]));

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s cycle=%0d got=%0h expected=%0h", tag, cyc, got, exp);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < NDUT; k++) begin
            m_owner[k] = -1;
            m_beats_done[k] = 0;
            m_beats_total[k] = 0;
            m_gap[k] = 0;
            m_ptr[k] = 0;
            m_sel[k] = 0;
        end
    endtask

    // Burst-level view: an owner with a count of beats still to move, then an idle gap, then arbitration.
    task automatic model_edge();
        for (int k = 0; k < NDUT; k++) begin
            if (reset) begin
                m_owner[k] = -1; m_gap[k] = 0; m_ptr[k] = 0; m_sel[k] = 0;
                m_beats_done[k] = 0;
            end else if (m_owner[k] >= 0) begin
                if (bus_ready) begin
                    m_beats_done[k]++;
                    if (m_beats_done[k] == m_beats_total[k]) begin
                        m_ptr[k] = (m_owner[k] + 1) % 4;
                        m_owner[k] = -1;
                        m_gap[k] = turn_of[k];
                    end
                end
            end else if (m_gap[k] > 0) begin
                m_gap[k]--;
            end else if (req != 4'd0) begin
                for (int i = 0; i < 4; i++) begin
                    int c;
                    c = (m_ptr[k] + i) % 4;
                    if (m_owner[k] < 0 && req[c]) begin
                        m_owner[k] = c;
                        m_sel[k] = c;
                        m_beats_done[k] = 0;
                        m_beats_total[k] = int'((req_len >> (c*LEN_W)) & 16'hF) + 1;
                    end
                end
            end
        end
    endtask

    task automatic compare_all();
        for (int k = 0; k < NDUT; k++) begin
            logic [3:0] e_gnt;
            logic       e_last;
            e_gnt  = (m_owner[k] >= 0) ? (4'b0001 << m_owner[k]) : 4'd0;
            e_last = (m_owner[k] >= 0) && bus_ready && (m_beats_done[k] + 1 == m_beats_total[k]);
            check($sformatf("gnt[t%0d]", turn_of[k]), 32'(gnt_a[k]), 32'(e_gnt));
            check($sformatf("drv_en[t%0d]", turn_of[k]), 32'(drv_en_a[k]), 32'(e_gnt));
            check($sformatf("sel[t%0d]", turn_of[k]), 32'(sel_a[k]), 32'(m_sel[k]));
            check($sformatf("beat_ack[t%0d]", turn_of[k]), 32'(beat_ack_a[k]),
                  32'(bus_ready ? e_gnt : 4'd0));
            check($sformatf("last_beat[t%0d]", turn_of[k]), 32'(last_a[k]), 32'(e_last));
            check($sformatf("busy[t%0d]", turn_of[k]), 32'(busy_a[k]),
                  32'((m_owner[k] >= 0) || (m_gap[k] > 0)));
            check($sformatf("onehot0[t%0d]", turn_of[k]), 32'($onehot0(drv_en_a[k])), 32'd1);
        end
    endtask

    // Inputs are applied just after a rising edge, checked at the falling edge, consumed at the next rising edge.
    task automatic cycle(input logic r, input logic [3:0] q, input logic [15:0] l, input logic rdy);
        reset = r; req = q; req_len = l; bus_ready = rdy;
        @(negedge clk);
        compare_all();
        @(posedge clk);
        model_edge();
        cyc++;
        #1;
    endtask

    task automatic settle();
        for (int i = 0; i < 24; i++) cycle(1'b0, 4'd0, 16'h0000, 1'b1);
    endtask

    logic [3:0]  rq;
    logic [15:0] rl;
    logic [6:0]  rdy_pat;

    initial begin
        reset = 1'b1; req = 4'd0; req_len = '0; bus_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        model_reset();
        cycle(1'b1, 4'd0, 16'h0000, 1'b0);

        // single 1-beat burst by requester 0
        cycle(1'b0, 4'b0001, 16'h0000, 1'b1);
        for (int i = 0; i < 8; i++) cycle(1'b0, 4'd0, 16'h0000, 1'b1);

        // all four requesting, 2-beat bursts, rotating order
        for (int i = 0; i < 30; i++) cycle(1'b0, 4'b1111, 16'h1111, 1'b1);
        settle();

        // requester 2, 4 beats, ready pattern 1,0,0,1,1,0,1 through the burst
        cycle(1'b0, 4'b0100, 16'h0300, 1'b1);
        rdy_pat = 7'b1011001;
        for (int i = 0; i < 7; i++) cycle(1'b0, 4'b0000, 16'h0000, rdy_pat[i]);
        settle();

        // requester 1 bursts 6 beats despite dropping req and changing len; req[3] pending
        cycle(1'b0, 4'b0010, 16'h0050, 1'b1);
        for (int i = 0; i < 5; i++) cycle(1'b0, 4'b1001, 16'h0000, 1'b1);
        for (int i = 0; i < 10; i++) cycle(1'b0, 4'b1001, 16'h0000, 1'b1);
        settle();

        // reset on the 3rd beat of an 8-beat burst, then requester 0 held
        cycle(1'b0, 4'b0001, 16'h0007, 1'b1);
        cycle(1'b0, 4'b0001, 16'h0007, 1'b1);
        cycle(1'b0, 4'b0001, 16'h0007, 1'b1);
        cycle(1'b1, 4'b0001, 16'h0007, 1'b1);
        for (int i = 0; i < 20; i++) cycle(1'b0, 4'b0001, 16'h0007, 1'b1);
        settle();

        // sole requester 1 with 1-beat bursts: exercises the 0 and 3 turnaround periods
        for (int i = 0; i < 20; i++) cycle(1'b0, 4'b0010, 16'h0000, 1'b1);
        settle();

        rq = 4'd0; rl = 16'd0;
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 3) == 0) rq = 4'($urandom);
            if ($urandom_range(0, 3) == 0) begin
                for (int j = 0; j < 4; j++)
                    rl[j*4 +: 4] = ($urandom_range(0, 7) == 0) ? 4'($urandom) : 4'($urandom_range(0, 2));
            end
            cycle(($urandom_range(0, 149) == 0), rq, rl, ($urandom_range(0, 3) != 0));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
